mdu_iter: RTL and testbench

- Multi-cycle RV32M multiply/divide unit, sitting beside the single-cycle ALU in the execute stage.
- Execute control is the initiator: it issues an operation and operands over a valid/ready request channel.
- This block is the responder: it iterates one bit per cycle and returns the result, with a zero flag, over a valid/ready response channel.
- It covers the M-extension ops the combinational ALU cannot do in one cycle.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_if.sv | 27 ++
 rtl/mdu_sign_fix.sv | 64 ++++++
 rtl/mdu_iter.sv | 158 +++++++++++++++
 tb/tb_mdu_iter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the iterative RV32M multiply/divide unit.
//   mdu_op_e   : RV32M funct3 encodings
//   state_e    : controller states
//   DIV_ZERO_Q : quotient returned on divide-by-zero
//   INT_MIN    : most negative 32-bit value (signed-overflow dividend)
package mdu_pkg;

  localparam int unsigned MDU_XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [MDU_XLEN-1:0] DIV_ZERO_Q = '1;
  localparam logic [MDU_XLEN-1:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/response channel between execute control (master) and the
// multiply/divide unit (slave).
//   request : in_valid, in_ready, op[2:0], a, b
//   response: out_valid, out_ready, result, zero_flag
interface mdu_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero_flag;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero_flag
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero_flag
  );
endinterface

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational sign handling around the unsigned iteration core.
//   Front end (request side): op_i, a_i, b_i -> operand magnitudes, effective
//   operand signs, and the RISC-V special-case flag/result (b==0, INT_MIN/-1).
//   Back end (finish side): fop_i, fsa_i, fsb_i, hi_i, lo_i -> final result,
//   where {hi,lo} is the unsigned product, or hi=remainder / lo=quotient.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = MDU_XLEN
) (
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] mag_a_o,
  output logic [XLEN-1:0] mag_b_o,
  output logic            sa_o,
  output logic            sb_o,
  output logic            special_o,
  output logic [XLEN-1:0] special_res_o,

  input  logic [2:0]      fop_i,
  input  logic            fsa_i,
  input  logic            fsb_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  output logic [XLEN-1:0] res_o
);

  localparam logic [XLEN-1:0] MIN_V  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES_V = '1;

  mdu_op_e op, fop;
  logic    a_signed, b_signed, ovf;
  logic [2*XLEN-1:0] prod, prod_s;

  always_comb begin
    op       = mdu_op_e'(op_i);
    a_signed = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    sa_o     = a_signed & a_i[XLEN-1];
    sb_o     = b_signed & b_i[XLEN-1];
    mag_a_o  = sa_o ? -a_i : a_i;
    mag_b_o  = sb_o ? -b_i : b_i;

    ovf           = (op inside {OP_DIV, OP_REM}) && (a_i == MIN_V) && (b_i == ONES_V);
    special_o     = op_i[2] && ((b_i == '0) || ovf);
    special_res_o = '0;
    if (b_i == '0) special_res_o = op_i[1] ? a_i : ONES_V;
    else if (ovf)  special_res_o = op_i[1] ? '0 : MIN_V;
  end

  always_comb begin
    fop    = mdu_op_e'(fop_i);
    prod   = {hi_i, lo_i};
    prod_s = (fsa_i ^ fsb_i) ? -prod : prod;
    case (fop)
      OP_MUL:                         res_o = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   res_o = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                res_o = (fsa_i ^ fsb_i) ? -lo_i : lo_i;
      default:                        res_o = fsa_i ? -hi_i : hi_i;  // remainder follows dividend
    endcase
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle RV32M multiply/divide unit, one bit per cycle.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   flush      : synchronous abort of any in-flight op (priority over handshakes)
//   bus.slave  : valid/ready request (op, a, b) and response (result, zero_flag)
// Both multiply and divide run on unsigned magnitudes in a shared hi/lo pair:
//   multiply: lo holds the multiplier, shifted right as the product fills hi:lo
//   divide  : lo holds the dividend, shifted left into hi while quotient bits fill lo
// After the XLEN-th iteration a separate finish cycle applies the sign fix-up,
// keeping the negation off the adder path. Special cases skip the iterations and
// use that finish cycle alone, so they return one cycle after accept.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = MDU_XLEN
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  mdu_if.slave bus
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fix_q, fix_d;    // next CALC cycle is the finish cycle
  logic            spec_q, spec_d;  // special case; lo holds the ready result
  logic [2:0]      op_q, op_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, mb_q, mb_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zf_q, zf_d;

  logic [XLEN-1:0] mag_a, mag_b, spec_res, fix_res;
  logic            sa, sb, special;
  logic [XLEN:0]   sum, shifted, diff;

  mdu_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op_i          (bus.op),
    .a_i           (bus.a),
    .b_i           (bus.b),
    .mag_a_o       (mag_a),
    .mag_b_o       (mag_b),
    .sa_o          (sa),
    .sb_o          (sb),
    .special_o     (special),
    .special_res_o (spec_res),
    .fop_i         (op_q),
    .fsa_i         (sa_q),
    .fsb_i         (sb_q),
    .hi_i          (hi_q),
    .lo_i          (lo_q),
    .res_o         (fix_res)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fix_d    = fix_q;
    spec_d   = spec_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mb_d     = mb_q;
    result_d = result_q;

    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, mb_q};

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d   = bus.op;
          sa_d   = sa;
          sb_d   = sb;
          cnt_d  = '0;
          hi_d   = '0;
          fix_d  = special;
          spec_d = special;
          state_d = ST_CALC;
          // mb is the multiplicand or the divisor; lo the multiplier or dividend
          mb_d = bus.op[2] ? mag_b : mag_a;
          lo_d = special ? spec_res : (bus.op[2] ? mag_a : mag_b);
        end
      end
      ST_CALC: begin
        if (fix_q) begin
          result_d = spec_q ? lo_q : fix_res;
          state_d  = ST_DONE;
        end else begin
          if (op_q[2]) begin
            // restoring step: keep the trial subtraction only if it did not borrow
            hi_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ~diff[XLEN]};
          end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) fix_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end

    zf_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      fix_q    <= 1'b0;
      spec_q   <= 1'b0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mb_q     <= '0;
      result_q <= '0;
      zf_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fix_q    <= fix_d;
      spec_q   <= spec_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mb_q     <= mb_d;
      result_q <= result_d;
      zf_q     <= zf_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.zero_flag = zf_q;

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  mdu_if #(.XLEN(32)) bus();

  mdu_iter #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // monitor: pops one expected result per response handshake
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_response: got 0x%08h with empty scoreboard", bus.result);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.result !== e || bus.zero_flag !== (e == 32'h0)) begin
          failures++;
          $display("FAIL response: got 0x%08h z=%0b expected 0x%08h z=%0b",
                   bus.result, bus.zero_flag, e, (e == 32'h0));
        end
      end
    end
  end

  // returns #1 after the accepting edge
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: in_ready never rose (op %0d)", o);
    end
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    if (push) exp_q.push_back(er);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // cycles from accept edge until out_valid is seen
  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1 lat++;
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) begin
      checks++;
      failures++;
      $display("FAIL wait_valid_timeout: out_valid did not rise within %0d cycles", lat);
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] er, input int explat);
    int lat;
    issue(o, x, y, er, 1'b1);
    wait_valid(lat);
    if (explat != 0) chk({name, "_latency"}, lat, explat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    bit rose;
    bus.in_valid = 1'b0;
    bus.op = 3'd0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_result", bus.result, 0);
    chk("reset_zero", bus.zero_flag, 1);
    rst = 1'b0;

    run("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run("div", 3'b100, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 33);
    run("rem", 3'b110, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, 0);
    run("divu", 3'b101, 32'd100, 32'd7, 32'd14, 0);
    run("remu", 3'b111, 32'd100, 32'd7, 32'd2, 0);
    run("div0", 3'b100, 32'd42, 32'd0, 32'hFFFF_FFFF, 1);
    run("remu0", 3'b111, 32'd42, 32'd0, 32'd42, 1);
    run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // backpressure and busy-request rules
    bus.out_ready = 1'b0;
    issue(3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op = 3'b000;
      bus.a = 32'd9;
      bus.b = 32'd9;
      @(posedge clk);
      #1 chk("busy_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_latency", lat, 28);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_result_hold", bus.result, 32'd14);
      chk("bp_valid_hold", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 chk("release_in_ready", bus.in_ready, 1);
    issue(3'b111, 32'd100, 32'd7, 32'd2, 1'b1);
    chk("next_accepted", bus.in_ready, 0);
    wait_valid(lat);
    @(posedge clk);
    #1;

    // flush at count 10
    issue(3'b000, 32'd3, 32'd3, 32'd9, 1'b0);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_in_ready", bus.in_ready, 1);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_result_kept", bus.result, 32'd2);
    rose = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.out_valid) rose = 1'b1;
    end
    chk("flush_no_valid", rose, 0);

    // reset mid-CALC
    issue(3'b000, 32'd3, 32'd3, 32'd9, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_in_ready", bus.in_ready, 1);
    chk("rst_mid_out_valid", bus.out_valid, 0);
    chk("rst_mid_result", bus.result, 0);
    chk("rst_mid_zero", bus.zero_flag, 1);
    rst = 1'b0;

    run("mul_after", 3'b000, 32'd100, 32'd50, 32'd5000, 33);

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
